// File: rtl/irq_ctrl_if.sv
// Peripheral register bus and core interrupt handshake bundle for irq_ctrl.
// master = bus/core side, slave = the interrupt controller.
interface irq_ctrl_if #(
    parameter int NUM_IRQ = 8
);
    logic [31:0]        i_addr_32b;
    logic               i_wren;
    logic               i_rden;
    logic [31:0]        i_din_32b;
    logic [31:0]        o_dout_32b;
    logic               o_dout_32b_valid;
    logic [NUM_IRQ-1:0] i_irq_src;
    logic               o_irq;
    logic [4:0]         o_irq_id;
    logic               i_irq_ack;

    modport master (
        output i_addr_32b, i_wren, i_rden, i_din_32b, i_irq_src, i_irq_ack,
        input  o_dout_32b, o_dout_32b_valid, o_irq, o_irq_id
    );

    modport slave (
        input  i_addr_32b, i_wren, i_rden, i_din_32b, i_irq_src, i_irq_ack,
        output o_dout_32b, o_dout_32b_valid, o_irq, o_irq_id
    );
endinterface

// File: rtl/irq_ctrl.sv
// Pending/enable interrupt controller with lowest-index priority, claim/ack handshake and ack counter.
// Define IRQ_EDGE_DETECT_EN to double-flop the sources and latch pending on rising edges only.
module irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    irq_ctrl_if.slave  bus
);
    localparam logic [4:0] REG_PENDING = 5'd0;
    localparam logic [4:0] REG_ENABLE  = 5'd1;
    localparam logic [4:0] REG_CLAIM   = 5'd2;
    localparam logic [4:0] REG_GIE     = 5'd3;
    localparam logic [4:0] REG_CNT     = 5'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic               gie;
    logic [31:0]        cnt;
    logic               irq;
    logic [4:0]         irq_id;
    logic [31:0]        dout;
    logic               dout_valid;

    function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (v[k]) lowest_idx = k[4:0];
        end
    endfunction

    function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
        zext = '0;
        zext[NUM_IRQ-1:0] = v;
    endfunction

    logic [4:0] sel;
    logic       wr_pending, wr_enable, wr_gie, wr_cnt;
    assign sel        = bus.i_addr_32b[6:2];
    assign wr_pending = bus.i_wren && (sel == REG_PENDING);
    assign wr_enable  = bus.i_wren && (sel == REG_ENABLE);
    assign wr_gie     = bus.i_wren && (sel == REG_GIE);
    assign wr_cnt     = bus.i_wren && (sel == REG_CNT);

    logic [NUM_IRQ-1:0] set_evt;
`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_s1, src_s2, src_s3;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
        end else begin
            src_s1 <= bus.i_irq_src;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
        end
    end
    assign set_evt = src_s2 & ~src_s3;
`else
    assign set_evt = bus.i_irq_src;
`endif

    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] id_onehot;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] pending_next;
    logic               id_still_valid;

    assign req            = pending & enable;
    assign id_onehot      = NUM_IRQ'(1) << irq_id;
    assign id_still_valid = gie && ((enable & id_onehot) != '0) && ((pending & id_onehot) != '0);
    assign ack_clr        = (state == ST_ASSERT && bus.i_irq_ack) ? id_onehot : '0;
    assign w1c_mask       = wr_pending ? bus.i_din_32b[NUM_IRQ-1:0] : '0;
    // New set events override both software W1C and the ack clear in the same cycle.
    assign pending_next   = (pending & ~w1c_mask & ~ack_clr) | set_evt;

    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        case (sel)
            REG_PENDING: rdata = zext(pending);
            REG_ENABLE:  rdata = zext(enable);
            REG_CLAIM:   rdata = {irq, 26'b0, irq_id};
            REG_GIE:     rdata = {31'b0, gie};
            REG_CNT:     rdata = cnt;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            enable     <= '0;
            gie        <= 1'b0;
            cnt        <= '0;
            irq        <= 1'b0;
            irq_id     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            pending    <= pending_next;
            dout_valid <= bus.i_wren | bus.i_rden;
            if (bus.i_rden) dout <= rdata;
            if (wr_enable)  enable <= bus.i_din_32b[NUM_IRQ-1:0];
            if (wr_gie)     gie <= bus.i_din_32b[0];

            case (state)
                ST_IDLE: begin
                    if (gie && (req != '0)) begin
                        irq_id <= lowest_idx(req);
                        irq    <= 1'b1;
                        state  <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    // The latched id is never re-arbitrated; only ack or withdrawal ends the request.
                    if (bus.i_irq_ack) begin
                        if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
                        irq   <= 1'b0;
                        state <= ST_GAP;
                    end else if (!id_still_valid) begin
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    irq   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            if (wr_cnt) cnt <= '0;
        end
    end

    assign bus.o_irq            = irq;
    assign bus.o_irq_id         = irq_id;
    assign bus.o_dout_32b       = dout;
    assign bus.o_dout_32b_valid = dout_valid;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a reference model.
// Honours IRQ_EDGE_DETECT_EN the same way the design does.
module tb_irq_ctrl;
    localparam int N = 8;
    localparam logic [31:0] MASK = 32'h0000_00FF;
`ifdef IRQ_EDGE_DETECT_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_ctrl_if #(.NUM_IRQ(N)) bus ();
    irq_ctrl #(.NUM_IRQ(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state; phase 0 = idle, 1 = requesting, 2 = gap.
    logic [31:0] m_pend, m_en, m_cnt, m_dout, m_s1, m_s2, m_s3;
    logic        m_gie, m_irq, m_dv;
    logic [4:0]  m_id;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] src, set, ackc, w1c, rdv, req, pend_n, en_n, cnt_n, dout_n;
        logic [4:0]  sel, id_n;
        logic        gie_n, irq_n, found;
        int          ph_n;
        if (rst) begin
            m_pend = 0; m_en = 0; m_cnt = 0; m_dout = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
            m_gie = 0; m_irq = 0; m_dv = 0; m_id = 0; m_phase = 0;
            return;
        end
        src = 32'(bus.i_irq_src);
`ifdef IRQ_EDGE_DETECT_EN
        set = m_s2 & ~m_s3;
`else
        set = src;
`endif
        sel = bus.i_addr_32b[6:2];
        case (sel)
            5'd0:    rdv = m_pend;
            5'd1:    rdv = m_en;
            5'd2:    rdv = {m_irq, 26'b0, m_id};
            5'd3:    rdv = {31'b0, m_gie};
            5'd4:    rdv = m_cnt;
            default: rdv = 0;
        endcase
        dout_n = bus.i_rden ? rdv : m_dout;
        ph_n = m_phase; irq_n = m_irq; id_n = m_id; ackc = 0; cnt_n = m_cnt;
        req = m_pend & m_en;
        if (m_phase == 0) begin
            if (m_gie && req != 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[k]) begin
                        id_n = 5'(k);
                        found = 1'b1;
                    end
                end
                irq_n = 1'b1;
                ph_n = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.i_irq_ack) begin
                ackc = 32'd1 << m_id;
                if (m_cnt != 32'hFFFF_FFFF) cnt_n = m_cnt + 1;
                irq_n = 1'b0;
                ph_n = 2;
            end else if (!m_en[m_id] || !m_gie || !m_pend[m_id]) begin
                irq_n = 1'b0;
                ph_n = 0;
            end
        end else begin
            ph_n = 0;
        end
        w1c    = (bus.i_wren && sel == 5'd0) ? bus.i_din_32b : 32'd0;
        pend_n = ((m_pend & ~w1c & ~ackc) | set) & MASK;
        en_n   = (bus.i_wren && sel == 5'd1) ? (bus.i_din_32b & MASK) : m_en;
        gie_n  = (bus.i_wren && sel == 5'd3) ? bus.i_din_32b[0] : m_gie;
        if (bus.i_wren && sel == 5'd4) cnt_n = 0;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = src & MASK;
        m_pend = pend_n; m_en = en_n; m_gie = gie_n; m_cnt = cnt_n;
        m_dout = dout_n; m_dv = bus.i_wren | bus.i_rden;
        m_irq = irq_n; m_id = id_n; m_phase = ph_n;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", 32'(bus.o_irq), 32'(m_irq));
        chk("irq_id", 32'(bus.o_irq_id), 32'(m_id));
        chk("dout_valid", 32'(bus.o_dout_32b_valid), 32'(m_dv));
        chk("dout", bus.o_dout_32b, m_dout);
    endtask

    task automatic idle_in();
        bus.i_addr_32b = 0; bus.i_wren = 0; bus.i_rden = 0; bus.i_din_32b = 0;
        bus.i_irq_src = 0; bus.i_irq_ack = 0;
    endtask

    function automatic logic [31:0] reg_addr(input int idx);
        return ($urandom & 32'hFFFF_FF83) | (32'(idx) << 2);
    endfunction

    task automatic wr(input int idx, input logic [31:0] data);
        bus.i_addr_32b = reg_addr(idx); bus.i_din_32b = data; bus.i_wren = 1;
        tick();
        bus.i_wren = 0; bus.i_din_32b = 0;
    endtask

    task automatic rd(input int idx, output logic [31:0] data);
        bus.i_addr_32b = reg_addr(idx); bus.i_rden = 1;
        tick();
        bus.i_rden = 0;
        data = bus.o_dout_32b;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.i_irq_src = m;
        tick();
        bus.i_irq_src = 0;
        repeat (EXTRA) tick();
    endtask

    task automatic ack();
        bus.i_irq_ack = 1;
        tick();
        bus.i_irq_ack = 0;
    endtask

    task automatic wait_irq(input string tag, input logic [4:0] exp_id);
        int c = 0;
        while (!bus.o_irq && c < 8) begin
            tick();
            c++;
        end
        chk({tag, "_seen"}, 32'(bus.o_irq), 32'd1);
        chk({tag, "_id"}, 32'(bus.o_irq_id), 32'(exp_id));
    endtask

    task automatic wait_low(input string tag);
        int c = 0;
        while (bus.o_irq && c < 4) begin
            tick();
            c++;
        end
        chk(tag, 32'(bus.o_irq), 32'd0);
    endtask

    logic [31:0] d;

    initial begin
        idle_in();
        rst = 1;
        tick(); tick();
        chk("rst_irq", 32'(bus.o_irq), 32'd0);
        chk("rst_id", 32'(bus.o_irq_id), 32'd0);
        chk("rst_valid", 32'(bus.o_dout_32b_valid), 32'd0);
        chk("rst_dout", bus.o_dout_32b, 32'd0);
        rst = 0;
        tick();

        // Single source request and ack.
        wr(1, 32'h1); wr(3, 32'h1);
        pulse(8'h01);
        rd(0, d);            chk("t1_pending", d, 32'h1);
        chk("t1_irq", 32'(bus.o_irq), 32'd1);
        chk("t1_id", 32'(bus.o_irq_id), 32'd0);
        ack();               chk("t1_irq_low", 32'(bus.o_irq), 32'd0);
        rd(0, d);            chk("t1_pending_clr", d, 32'h0);
        rd(4, d);            chk("t1_cnt", d, 32'd1);

        // Two simultaneous sources: lowest index first, gap between requests.
        wr(1, 32'hFF);
        pulse(8'h24);
        tick();              chk("t2_first_id", 32'(bus.o_irq_id), 32'd2);
        chk("t2_first_irq", 32'(bus.o_irq), 32'd1);
        ack();               chk("t2_gap", 32'(bus.o_irq), 32'd0);
        wait_irq("t2_second", 5'd5);
        ack();

        // Withdrawal by clearing ENABLE.
        pulse(8'h08);
        tick();              chk("t3_id", 32'(bus.o_irq_id), 32'd3);
        wr(1, 32'h0);
        wait_low("t3_drop");
        rd(0, d);            chk("t3_pending", d & 32'h8, 32'h8);
        rd(4, d);            chk("t3_cnt", d, 32'd3);
        wr(0, 32'hFF);
        rd(0, d);            chk("t3_w1c", d, 32'h0);

`ifndef IRQ_EDGE_DETECT_EN
        // Set event beats ack clear and W1C clear.
        wr(1, 32'hFF);
        pulse(8'h02);
        tick();              chk("t4_id", 32'(bus.o_irq_id), 32'd1);
        bus.i_irq_src = 8'h02; bus.i_irq_ack = 1;
        tick();
        bus.i_irq_src = 0; bus.i_irq_ack = 0;
        chk("t4_irq_low", 32'(bus.o_irq), 32'd0);
        rd(0, d);            chk("t4_pending_kept", d, 32'h2);
        wait_irq("t4_rereq", 5'd1);
        ack();
        bus.i_addr_32b = reg_addr(0); bus.i_din_32b = 32'h2; bus.i_wren = 1; bus.i_irq_src = 8'h02;
        tick();
        idle_in();
        rd(0, d);            chk("t4_w1c_set", d, 32'h2);
        wr(1, 32'h0); wr(0, 32'hFF);
        repeat (3) tick();
`endif

        // CLAIM readback and CNT clear.
        wr(1, 32'hFF);
        pulse(8'h10);
        tick();
        rd(2, d);            chk("t5_claim", d, 32'h8000_0004);
        chk("t5_valid", 32'(bus.o_dout_32b_valid), 32'd1);
        tick();              chk("t5_valid_low", 32'(bus.o_dout_32b_valid), 32'd0);
        ack();
        wr(4, 32'h1234);
        rd(4, d);            chk("t5_cnt_clr", d, 32'd0);
        rd(6, d);            chk("t5_unmapped", d, 32'd0);

`ifdef IRQ_EDGE_DETECT_EN
        // A held-high source sets pending once.
        bus.i_irq_src = 8'h01;
        repeat (10) tick();
        bus.i_irq_src = 0;
        repeat (4) tick();
        chk("t6_irq", 32'(bus.o_irq), 32'd1);
        chk("t6_id", 32'(bus.o_irq_id), 32'd0);
        ack();
        repeat (5) tick();
        chk("t6_no_rereq", 32'(bus.o_irq), 32'd0);
        rd(4, d);            chk("t6_cnt", d, 32'd1);
        rd(0, d);            chk("t6_pending", d, 32'd0);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        wr(3, 32'h1);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.i_irq_src = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            bus.i_irq_ack = ($urandom_range(0, 3) == 0);
            if (r < 8) begin
                bus.i_addr_32b = reg_addr(int'($urandom_range(0, 7)));
                bus.i_din_32b  = (r < 3) ? 32'h1 : $urandom;
                bus.i_wren     = 1;
            end else if (r < 20) begin
                bus.i_addr_32b = reg_addr(int'($urandom_range(0, 7)));
                bus.i_rden     = 1;
            end
            if (i == 200) rst = 1;
            tick();
            rst = 0;
            idle_in();
            if (i == 200) begin
                wr(1, 32'hFF); wr(3, 32'h1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
